load_store_unit: RTL and testbench

Load/store unit between the execute stage and the word-addressed data memory (`DataMem`) of the RV32 core. It accepts one RV32 load or store per request and converts the byte address to a word index. For loads it extracts and sign- or zero-extends bytes and halfwords. For byte and halfword stores it performs a read-modify-write, because the memory only writes full words. It also flags misaligned, illegal or out-of-range accesses without touching memory.

---
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store unit with byte/half extraction and read-modify-write stores
module load_store_unit #(
   parameter int MEM_WORDS = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy,
   output logic        d_r_en,
   output logic        d_w_en,
   output logic [31:0] d_add,
   output logic [31:0] data_in,
   input  logic [31:0] d_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_WRITE,
      S_RESP
   } state_t;

   localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

   state_t      state;
   state_t      state_next;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] word_q;   // store data at acceptance, merged word after the read
   logic        err_q;
   logic        accept;
   logic        req_err;
   logic [31:0] word_idx;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] load_val;
   logic [31:0] merged;

   assign accept   = req_valid && req_ready;
   assign word_idx = {2'b00, addr_q[31:2]};

   // Classify the incoming request as illegal before it is accepted
   always_comb begin
      req_err = 1'b0;
      case (req_funct3)
         3'b001, 3'b101: if (req_addr[0]) req_err = 1'b1;
         3'b010:         if (req_addr[1:0] != 2'b00) req_err = 1'b1;
         3'b011, 3'b110, 3'b111: req_err = 1'b1;
         default: ;
      endcase
      if (req_we && req_funct3[2]) req_err = 1'b1;
      if ({2'b00, req_addr[31:2]} >= MEM_WORDS_W) req_err = 1'b1;
   end

   // Lane extraction for loads and lane replacement for narrow stores
   always_comb begin
      byte_v   = d_out[{addr_q[1:0], 3'b000} +: 8];
      half_v   = d_out[{addr_q[1], 4'b0000} +: 16];
      load_val = d_out;
      merged   = d_out;
      case (f3_q[1:0])
         2'b00: begin
            load_val = {{24{~f3_q[2] & byte_v[7]}}, byte_v};
            merged[{addr_q[1:0], 3'b000} +: 8] = word_q[7:0];
         end
         2'b01: begin
            load_val = {{16{~f3_q[2] & half_v[15]}}, half_v};
            merged[{addr_q[1], 4'b0000} +: 16] = word_q[15:0];
         end
         default: ;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   // Next-state decode
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (req_err)                             state_next = S_RESP;
               else if (req_we && req_funct3 == 3'b010) state_next = S_WRITE;
               else                                     state_next = S_READ;
            end
         end
         S_READ:  state_next = S_WAIT;
         S_WAIT:  state_next = we_q ? S_WRITE : S_RESP;
         S_WRITE: state_next = S_RESP;
         S_RESP:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Moore outputs; enables are gated by reset so a reset cycle never touches memory
   always_comb begin
      req_ready  = (state == S_IDLE) && rst;
      busy       = (state != S_IDLE);
      resp_valid = (state == S_RESP) && rst;
      resp_err   = (state == S_RESP) && rst && err_q;
      d_r_en     = (state == S_READ) && rst;
      d_w_en     = (state == S_WRITE) && rst;
      d_add      = ((state == S_READ) || (state == S_WRITE)) ? word_idx : 32'h0;
      data_in    = (state == S_WRITE) ? word_q : 32'h0;
   end

   // Request latch, merge register and response data
   always_ff @(posedge clk) begin
      if (!rst) begin
         we_q       <= 1'b0;
         f3_q       <= 3'b000;
         addr_q     <= 32'h0;
         word_q     <= 32'h0;
         err_q      <= 1'b0;
         resp_rdata <= 32'h0;
      end else begin
         if (accept) begin
            we_q   <= req_we;
            f3_q   <= req_funct3;
            addr_q <= req_addr;
            word_q <= req_wdata;
            err_q  <= req_err;
            if (req_err) resp_rdata <= 32'h0;
         end
         if (state == S_WAIT) begin
            if (we_q) word_q     <= merged;
            else      resp_rdata <= load_val;
         end
         if (state == S_WRITE) resp_rdata <= 32'h0;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a word-memory model
module tb_load_store_unit;

   localparam int MEM = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        busy;
   logic        d_r_en;
   logic        d_w_en;
   logic [31:0] d_add;
   logic [31:0] data_in;
   logic [31:0] d_out = 32'h0;

   int tests_run = 0;
   int fails = 0;
   int r_cnt = 0;
   int w_cnt = 0;
   int both_cnt = 0;

   logic [31:0] mem [MEM];
   logic [31:0] ref_mem [MEM];

   load_store_unit #(.MEM_WORDS(MEM)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .busy(busy), .d_r_en(d_r_en), .d_w_en(d_w_en), .d_add(d_add),
      .data_in(data_in), .d_out(d_out)
   );

   always #5 clk = ~clk;

   // Registered data memory: read data appears the cycle after the enable
   always @(posedge clk) begin
      if (d_w_en && d_add < MEM) mem[d_add] <= data_in;
      if (d_r_en && d_add < MEM) d_out <= mem[d_add];
   end

   // Enable activity monitor
   always @(negedge clk) begin
      if (d_r_en) r_cnt++;
      if (d_w_en) w_cnt++;
      if (d_r_en && d_w_en) both_cnt++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic bit model_err(input bit we, input int f3, input logic [31:0] addr);
      bit e = 0;
      if (f3 == 3 || f3 == 6 || f3 == 7) e = 1;
      if (we && f3 >= 4) e = 1;
      if ((f3 == 1 || f3 == 5) && (addr % 2 != 0)) e = 1;
      if (f3 == 2 && (addr % 4 != 0)) e = 1;
      if ((addr / 4) >= MEM) e = 1;
      return e;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] word, input int f3, input logic [31:0] addr);
      logic [31:0] v;
      int off = int'(addr % 4);
      case (f3)
         0, 4: begin
            v = (word >> (8 * off)) & 32'hFF;
            if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
         end
         1, 5: begin
            v = (word >> (16 * (off / 2))) & 32'hFFFF;
            if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
         end
         default: v = word;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] word, input int f3, input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] mask;
      int sh;
      if (f3 == 2) return wdata;
      sh = (f3 == 0) ? 8 * int'(addr % 4) : 16 * int'((addr % 4) / 2);
      mask = ((f3 == 0) ? 32'hFF : 32'hFFFF) << sh;
      return (word & ~mask) | ((wdata << sh) & mask);
   endfunction

   function automatic int model_lat(input bit we, input int f3, input logic [31:0] addr);
      if (model_err(we, f3, addr)) return 1;
      if (we && f3 == 2) return 2;
      if (we) return 4;
      return 3;
   endfunction

   task automatic model_apply(input bit we, input int f3, input logic [31:0] addr, input logic [31:0] wdata);
      if (we && !model_err(we, f3, addr))
         ref_mem[addr / 4] = model_store(ref_mem[addr / 4], f3, addr, wdata);
   endtask

   // ---------------- transaction driver (called at a negedge) ----------------
   task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int rd_at, output int wr_at, output logic [31:0] wr_add, output logic [31:0] wr_data);
      int w = 0;
      lat = 0; rdata = 0; err = 0; rd_at = 0; wr_at = 0; wr_add = 0; wr_data = 0;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) begin
         tests_run++;
         fails++;
         $display("FAIL req_ready_wait: req_ready=%0b required 1", req_ready);
         return;
      end
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      for (int k = 1; k <= 12 && lat == 0; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
         if (d_r_en && rd_at == 0) rd_at = k;
         if (d_w_en && wr_at == 0) begin
            wr_at = k; wr_add = d_add; wr_data = data_in;
         end
         if (resp_valid) begin
            lat = k; rdata = resp_rdata; err = resp_err;
         end
      end
      model_apply(we, int'(f3), addr, wdata);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({req_ready, resp_valid, resp_err, busy, d_r_en, d_w_en} !== 6'b0) begin
         fails++;
         $display("FAIL reset_flags: ready/valid/err/busy/ren/wen=%b required 000000",
                  {req_ready, resp_valid, resp_err, busy, d_r_en, d_w_en});
      end
      tests_run++;
      if ({resp_rdata, d_add, data_in} !== 96'h0) begin
         fails++;
         $display("FAIL reset_data: rdata=%h d_add=%h data_in=%h required 0", resp_rdata, d_add, data_in);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (req_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_ready: got %b required 1", req_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_word_round_trip;
      int lat, rd_at, wr_at; logic [31:0] rdata, wa, wd; logic err;
      do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rdata, err, rd_at, wr_at, wa, wd);
      tests_run++;
      if (wr_at !== 1 || wa !== 32'd4 || wd !== 32'hDEADBEEF || lat !== 2 || rd_at !== 0) begin
         fails++;
         $display("FAIL sw_timing: wr_at=%0d d_add=%h data_in=%h lat=%0d rd_at=%0d required 1/4/deadbeef/2/0",
                  wr_at, wa, wd, lat, rd_at);
      end
      do_req(0, 3'b010, 32'h10, 32'h0, lat, rdata, err, rd_at, wr_at, wa, wd);
      tests_run++;
      if (rdata !== 32'hDEADBEEF || lat !== 3 || rd_at !== 1 || err !== 1'b0) begin
         fails++;
         $display("FAIL lw_round_trip: rdata=%h lat=%0d rd_at=%0d err=%b required deadbeef/3/1/0", rdata, lat, rd_at, err);
      end
   endtask

   task automatic test_load_ext;
      logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
      logic [31:0] adrs [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
      logic [31:0] exps [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF, 32'hFFFFFFEF};
      int lat, rd_at, wr_at; logic [31:0] rdata, wa, wd; logic err;
      for (int i = 0; i < 5; i++) begin
         do_req(0, f3s[i], adrs[i], 32'h0, lat, rdata, err, rd_at, wr_at, wa, wd);
         tests_run++;
         if (rdata !== exps[i] || lat !== 3) begin
            fails++;
            $display("FAIL load_ext[%0d]: rdata=%h lat=%0d required %h/3", i, rdata, lat, exps[i]);
         end
      end
   endtask

   task automatic test_rmw;
      int lat, rd_at, wr_at; logic [31:0] rdata, wa, wd; logic err;
      do_req(1, 3'b000, 32'h11, 32'h123456AA, lat, rdata, err, rd_at, wr_at, wa, wd);
      tests_run++;
      if (rd_at !== 1 || wr_at !== 3 || wd !== 32'hDEADAAEF || wa !== 32'd4 || lat !== 4 || rdata !== 32'h0) begin
         fails++;
         $display("FAIL sb_rmw: rd_at=%0d wr_at=%0d data_in=%h d_add=%h lat=%0d rdata=%h required 1/3/deadaaef/4/4/0",
                  rd_at, wr_at, wd, wa, lat, rdata);
      end
      do_req(1, 3'b001, 32'h12, 32'h00001234, lat, rdata, err, rd_at, wr_at, wa, wd);
      tests_run++;
      if (wd !== 32'h1234AAEF || lat !== 4) begin
         fails++;
         $display("FAIL sh_rmw: data_in=%h lat=%0d required 1234aaef/4", wd, lat);
      end
      do_req(0, 3'b010, 32'h10, 32'h0, lat, rdata, err, rd_at, wr_at, wa, wd);
      tests_run++;
      if (rdata !== 32'h1234AAEF) begin
         fails++;
         $display("FAIL rmw_readback: rdata=%h required 1234aaef", rdata);
      end
   endtask

   task automatic test_errors;
      bit          wes  [5] = '{0, 0, 0, 1, 1};
      logic [2:0]  f3s  [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010};
      logic [31:0] adrs [5] = '{32'h12, 32'h11, 32'h10, 32'h10, 32'h190};
      int lat, rd_at, wr_at, r0, w0; logic [31:0] rdata, wa, wd; logic err;
      for (int i = 0; i < 5; i++) begin
         r0 = r_cnt; w0 = w_cnt;
         do_req(wes[i], f3s[i], adrs[i], 32'hA5A5A5A5, lat, rdata, err, rd_at, wr_at, wa, wd);
         @(negedge clk);
         tests_run++;
         if (err !== 1'b1 || lat !== 1 || rdata !== 32'h0 || r_cnt !== r0 || w_cnt !== w0) begin
            fails++;
            $display("FAIL error[%0d]: err=%b lat=%0d rdata=%h reads=%0d writes=%0d required 1/1/0/0/0",
                     i, err, lat, rdata, r_cnt - r0, w_cnt - w0);
         end
      end
   endtask

   task automatic test_back_to_back;
      bit ready_log [11];
      bit valid_log [11];
      logic [31:0] rd_log [11];
      logic [31:0] exp_a, exp_b;
      while (!req_ready) @(negedge clk);
      exp_a = ref_mem[5];
      exp_b = ref_mem[9];
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14; req_wdata = 32'h0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) req_addr = 32'h24;
         if (k == 5) req_valid = 1'b0;
         ready_log[k] = req_ready;
         valid_log[k] = resp_valid;
         rd_log[k] = resp_rdata;
      end
      tests_run++;
      if (ready_log[1] || ready_log[2] || ready_log[3] || !ready_log[4]) begin
         fails++;
         $display("FAIL b2b_ready: N+1..N+4=%b%b%b%b required 0001", ready_log[1], ready_log[2], ready_log[3], ready_log[4]);
      end
      tests_run++;
      if (!valid_log[3] || rd_log[3] !== exp_a) begin
         fails++;
         $display("FAIL b2b_first: valid=%b rdata=%h required 1/%h", valid_log[3], rd_log[3], exp_a);
      end
      tests_run++;
      if (valid_log[4] || valid_log[5] || valid_log[6] || !valid_log[7] || rd_log[7] !== exp_b || valid_log[8]) begin
         fails++;
         $display("FAIL b2b_second: valid N+4..N+8=%b%b%b%b%b rdata=%h required 00010/%h",
                  valid_log[4], valid_log[5], valid_log[6], valid_log[7], valid_log[8], rd_log[7], exp_b);
      end
   endtask

   task automatic test_reset_mid;
      int w0, v_seen;
      while (!req_ready) @(negedge clk);
      w0 = w_cnt; v_seen = 0;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h11; req_wdata = 32'h000000CC;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests_run++;
      if (req_ready !== 1'b1) begin
         fails++;
         $display("FAIL rmw_reset_ready: got %b required 1", req_ready);
      end
      for (int k = 0; k < 5; k++) begin
         if (resp_valid) v_seen++;
         @(negedge clk);
      end
      tests_run++;
      if (w_cnt !== w0 || v_seen !== 0 || mem[4] !== ref_mem[4]) begin
         fails++;
         $display("FAIL rmw_reset_abort: writes=%0d resp=%0d word=%h required 0/0/%h", w_cnt - w0, v_seen, mem[4], ref_mem[4]);
      end
      while (!req_ready) @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = ~ref_mem[8];
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b0;
      #1;
      tests_run++;
      if (d_w_en !== 1'b0) begin
         fails++;
         $display("FAIL write_reset_gate: d_w_en=%b required 0", d_w_en);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (mem[8] !== ref_mem[8] || busy !== 1'b0) begin
         fails++;
         $display("FAIL write_reset_abort: word=%h busy=%b required %h/0", mem[8], busy, ref_mem[8]);
      end
   endtask

   task automatic test_random;
      int lat, rd_at, wr_at, f3, e_lat; logic [31:0] rdata, wa, wd, addr, wdata, e_rd; logic err, e_err;
      bit we;
      int bad = 0;
      for (int i = 0; i < 80; i++) begin
         we = 1'($urandom_range(0, 1));
         f3 = (i % 3 == 0) ? $urandom_range(0, 7) : int'($urandom_range(0, 2)) + (we ? 0 : 4 * int'($urandom_range(0, 1)));
         if (f3 == 6) f3 = 2;
         addr = 32'($urandom_range(0, MEM + 1)) * 4 + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) addr = addr | 32'h8000_0000;
         wdata = $urandom;
         e_err = model_err(we, f3, addr);
         e_lat = model_lat(we, f3, addr);
         e_rd = (e_err || we) ? 32'h0 : model_load(ref_mem[addr / 4], f3, addr);
         do_req(we, 3'(f3), addr, wdata, lat, rdata, err, rd_at, wr_at, wa, wd);
         tests_run++;
         if (err !== e_err || lat !== e_lat || rdata !== e_rd) begin
            fails++;
            bad++;
            if (bad < 10)
               $display("FAIL random[%0d] we=%0d f3=%0d addr=%h: err=%b lat=%0d rdata=%h required %b/%0d/%h",
                        i, we, f3, addr, err, lat, rdata, e_err, e_lat, e_rd);
         end
      end
   endtask

   task automatic test_memory_image;
      int diff = 0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < MEM; i++) if (mem[i] !== ref_mem[i]) diff++;
      tests_run++;
      if (diff !== 0) begin
         fails++;
         $display("FAIL memory_image: %0d words differ, required 0", diff);
      end
      tests_run++;
      if (both_cnt !== 0) begin
         fails++;
         $display("FAIL enable_exclusive: %0d cycles with both enables, required 0", both_cnt);
      end
   endtask

   initial begin
      for (int i = 0; i < MEM; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      @(negedge clk);
      test_reset();
      test_word_round_trip();
      test_load_ext();
      test_rmw();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_memory_image();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
